gelato_ibuffer: RTL and testbench
=================================

GELATO_IBUFFER -- requirements
Module: gelato_ibuffer

Interface
REQ-001 Parameter NUM_WARPS, default 8, number of warps; SHALL be a power of 2 and at least 2.
REQ-002 Parameter DEPTH, default 4, entries per warp FIFO; SHALL be a power of 2 and at least 2.
REQ-003 Parameters ADDR_W 32 (pc width), THREAD_NUM 32 (thread mask width), INST_W 128 (packed decoded inst width); WARP_W = log2(NUM_WARPS).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  decoded instruction from I-Decode present this cycle.
REQ-007 in_pc  in  ADDR_W, in_warp_num  in  WARP_W, in_thread_mask  in  THREAD_NUM, in_inst  in  INST_W  payload qualified by in_valid.
REQ-008 warp_full  out  NUM_WARPS  per-warp FIFO full; upstream SHALL NOT fetch for a full warp.
REQ-009 warp_empty  out  NUM_WARPS  per-warp FIFO empty.
REQ-010 flush_valid  in  1, flush_warp  in  WARP_W  discard all entries of flush_warp.
REQ-011 out_valid  out  1, out_ready  in  1  issue handshake; transfer when both high.
REQ-012 out_pc, out_warp_num, out_thread_mask, out_inst  out  same widths as inputs  head entry of selected warp.
REQ-013 overflow  out  1  sticky error: a push hit a full warp.

Function
REQ-014 Each warp SHALL own an independent FIFO of DEPTH entries holding {pc, thread_mask, inst}, with read and write pointers and a count of width log2(DEPTH)+1.
REQ-015 Push: in_valid high -> entry written to FIFO in_warp_num at next edge; count +1.
REQ-016 warp_full[w] = (count[w]==DEPTH); warp_empty[w] = (count[w]==0); both derived from registered counts only.
REQ-017 Push to a full warp with no same-warp pop that cycle SHALL be dropped, with no state change except that overflow sets to 1 and holds until reset.
REQ-018 Push and pop to the same full warp in the same cycle SHALL both be accepted; count unchanged; overflow unchanged.
REQ-019 Selection: combinational round-robin; sel = first warp w with count[w]!=0, searching rr_ptr, rr_ptr+1, ... modulo NUM_WARPS.
REQ-020 out_valid SHALL be 1 iff some warp is non-empty and sel != flush_warp while flush_valid is high.
REQ-021 out_* SHALL show the head entry of sel with out_warp_num=sel, combinationally (zero-cycle latency from FIFO head).
REQ-022 Pop occurs when out_valid && out_ready; the sel read pointer advances and its count decrements at next edge, and rr_ptr <= (sel+1) mod NUM_WARPS.
REQ-023 rr_ptr SHALL remain unchanged when no pop occurs.
REQ-024 out_* SHALL hold stable while out_valid && !out_ready, unless a push or flush changes rr order; the payload of the selected entry SHALL never change while it is presented.
REQ-025 Flush: flush_valid high -> at next edge flush_warp count=0, rd_ptr=wr_ptr; a same-cycle push to flush_warp SHALL be dropped (flush wins; overflow unaffected).
REQ-026 Flush of one warp SHALL NOT alter any other warp's FIFO, push or pop in that cycle.
REQ-027 Pointers SHALL wrap modulo DEPTH; read and write pointer equality SHALL NOT alone distinguish full from empty (use count).
REQ-028 Single-entry warp: push and pop in the same cycle -> count unchanged, new entry becomes head.

Reset
REQ-029 While rst_n=0, immediately and regardless of clk: all counts, pointers and rr_ptr SHALL be 0, overflow=0, warp_full=0, warp_empty=all 1s, out_valid=0.
REQ-030 FIFO storage need not be reset; out_pc, out_thread_mask and out_inst are don't-care while out_valid=0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered instructions; the first push after deassertion SHALL be accepted at the first rising edge.

Verification
REQ-032 Push warps 3,1,3 (pc 0x100,0x200,0x104), out_ready=1 -> issue order warp1 pc 0x200, warp3 pc 0x100, warp3 pc 0x104; rr_ptr ends at 4.
REQ-033 Push 4 entries to warp 2 (DEPTH=4) -> warp_full[2]=1; 5th push with out_ready=0 -> dropped, overflow=1, 4 entries drain intact in order.
REQ-034 Warp 5 full, push warp 5 with out_ready=1 and sel=5 -> head popped, new entry accepted, warp_full[5] stays 1, overflow=0.
REQ-035 Warp 0 holds 2 entries, warp 6 holds 1; flush_warp=0 with a same-cycle push to 0 -> out_valid selects warp 6 that cycle, warp 0 empty next cycle.
REQ-036 Warps 0..7 each hold 1 entry, out_ready=1 for 8 cycles -> one issue per cycle in order 0..7, then out_valid=0 and warp_empty=8'hFF.
REQ-037 Assert rst_n=0 between clock edges with 3 entries buffered -> out_valid=0 and warp_empty all 1s immediately; after deassertion a push to warp 4 issues.

Source files
------------

// File: rtl/gelato_ibuffer.sv
// gelato_ibuffer -- per-warp instruction buffer between I-Decode and issue.
//
// Each warp owns a small FIFO of decoded instructions {pc, thread_mask, inst}.
// A combinational round-robin arbiter presents the head of one non-empty warp
// on the issue port; a transfer happens when out_valid && out_ready.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid, in_pc, in_warp_num,
//   in_thread_mask, in_inst        decoded instruction push
//   warp_full, warp_empty          per-warp occupancy flags (registered counts)
//   flush_valid, flush_warp        discard every entry of one warp
//   out_valid, out_ready           issue handshake
//   out_pc, out_warp_num,
//   out_thread_mask, out_inst      head entry of the selected warp
//   overflow                       sticky: a push was dropped on a full warp
module gelato_ibuffer #(
  parameter int NUM_WARPS  = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 32,
  parameter int THREAD_NUM = 32,
  parameter int INST_W     = 128,
  localparam int WARP_W    = $clog2(NUM_WARPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [ADDR_W-1:0]     in_pc,
  input  logic [WARP_W-1:0]     in_warp_num,
  input  logic [THREAD_NUM-1:0] in_thread_mask,
  input  logic [INST_W-1:0]     in_inst,
  output logic [NUM_WARPS-1:0]  warp_full,
  output logic [NUM_WARPS-1:0]  warp_empty,
  input  logic                  flush_valid,
  input  logic [WARP_W-1:0]     flush_warp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     out_pc,
  output logic [WARP_W-1:0]     out_warp_num,
  output logic [THREAD_NUM-1:0] out_thread_mask,
  output logic [INST_W-1:0]     out_inst,
  output logic                  overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]     pc;
    logic [THREAD_NUM-1:0] mask;
    logic [INST_W-1:0]     inst;
  } entry_t;

  entry_t           mem    [NUM_WARPS][DEPTH];
  logic [CNT_W-1:0] cnt    [NUM_WARPS];
  logic [PTR_W-1:0] rd_ptr [NUM_WARPS];
  logic [PTR_W-1:0] wr_ptr [NUM_WARPS];

  logic [WARP_W-1:0]    rr_ptr;
  logic [WARP_W-1:0]    sel;
  logic [WARP_W-1:0]    idx;
  logic                 found;
  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] push_w, pop_w, flush_w;
  logic                 pop;
  logic                 push_flushed, push_full, pop_same;
  logic                 push_ok, ovf_set;
  entry_t               head;

  // Occupancy flags. A warp being flushed this cycle is not offered for issue,
  // so the arbiter moves on to the next non-empty warp instead of stalling.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      warp_full[w]  = (cnt[w] == CNT_W'(DEPTH));
      warp_empty[w] = (cnt[w] == '0);
      eligible[w]   = !warp_empty[w] && !(flush_valid && flush_warp == WARP_W'(w));
    end
  end

  // Round-robin search starting at rr_ptr; WARP_W-bit addition wraps modulo
  // NUM_WARPS because NUM_WARPS is a power of two.
  always_comb begin
    // NOTE: every combinational output is given a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    sel   = rr_ptr;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      idx = rr_ptr + WARP_W'(i);
      if (!found && eligible[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign out_valid       = |eligible;
  assign pop             = out_valid && out_ready;
  assign head            = mem[sel][rd_ptr[sel]];
  assign out_pc          = head.pc;
  assign out_thread_mask = head.mask;
  assign out_inst        = head.inst;
  assign out_warp_num    = sel;

  // Push acceptance: flush of the target warp always wins; a full warp only
  // accepts when its head leaves in the same cycle.
  always_comb begin
    push_flushed = flush_valid && (flush_warp == in_warp_num);
    push_full    = warp_full[in_warp_num];
    pop_same     = pop && (sel == in_warp_num);
    push_ok      = in_valid && !push_flushed && (!push_full || pop_same);
    ovf_set      = in_valid && !push_flushed && push_full && !pop_same;
  end

  always_comb begin
    push_w  = '0;
    pop_w   = '0;
    flush_w = '0;
    if (flush_valid) flush_w[flush_warp] = 1'b1;
    if (pop)         pop_w[sel]          = 1'b1;
    if (push_ok)     push_w[in_warp_num] = 1'b1;
  end

  // NOTE: payload storage has no reset; validity is carried entirely by the
  // counts, which keeps the array free of reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) mem[in_warp_num][wr_ptr[in_warp_num]] <= '{pc: in_pc, mask: in_thread_mask, inst: in_inst};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        cnt[w]    <= '0;
        rd_ptr[w] <= '0;
        wr_ptr[w] <= '0;
      end
      rr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (flush_w[w]) begin
          cnt[w]    <= '0;
          rd_ptr[w] <= wr_ptr[w];
        end else begin
          cnt[w]    <= cnt[w] + CNT_W'(push_w[w]) - CNT_W'(pop_w[w]);
          wr_ptr[w] <= wr_ptr[w] + PTR_W'(push_w[w]);
          rd_ptr[w] <= rd_ptr[w] + PTR_W'(pop_w[w]);
        end
      end
      if (pop)     rr_ptr   <= sel + WARP_W'(1);
      if (ovf_set) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gelato_ibuffer.sv
// Self-checking bench for gelato_ibuffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_gelato_ibuffer;

  localparam int NW    = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [31:0]  in_pc;
  logic [2:0]   in_warp_num;
  logic [31:0]  in_thread_mask;
  logic [127:0] in_inst;
  logic [7:0]   warp_full, warp_empty;
  logic         flush_valid;
  logic [2:0]   flush_warp;
  logic         out_valid, out_ready;
  logic [31:0]  out_pc;
  logic [2:0]   out_warp_num;
  logic [31:0]  out_thread_mask;
  logic [127:0] out_inst;
  logic         overflow;

  gelato_ibuffer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_pc(in_pc), .in_warp_num(in_warp_num),
    .in_thread_mask(in_thread_mask), .in_inst(in_inst),
    .warp_full(warp_full), .warp_empty(warp_empty),
    .flush_valid(flush_valid), .flush_warp(flush_warp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_warp_num(out_warp_num),
    .out_thread_mask(out_thread_mask), .out_inst(out_inst),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  mask;
    logic [127:0] inst;
  } ent_t;

  // Reference model: one queue per warp, round-robin pointer, sticky error.
  ent_t q [NW][$];
  int   m_rr;
  logic m_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  int          iss_w  [$];
  logic [31:0] iss_pc [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NW; w++) q[w].delete();
    m_rr  = 0;
    m_ovf = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check #1 later, update model at posedge.
  task automatic step(input logic v, input int w, input logic [31:0] pc,
                      input logic fv, input int fw, input logic rdy);
    int   sel;
    logic exp_v;
    logic [7:0] exp_full, exp_empty;
    ent_t e;
    e = '{pc: pc, mask: $urandom, inst: {$urandom, $urandom, $urandom, $urandom}};
    in_valid       = v;
    in_warp_num    = 3'(w);
    in_pc          = e.pc;
    in_thread_mask = e.mask;
    in_inst        = e.inst;
    flush_valid    = fv;
    flush_warp     = 3'(fw);
    out_ready      = rdy;
    #1;
    sel = -1;
    for (int i = 0; i < NW; i++) begin
      int c;
      c = (m_rr + i) % NW;
      if (sel < 0 && q[c].size() != 0 && !(fv && fw == c)) sel = c;
    end
    exp_v = (sel >= 0);
    for (int i = 0; i < NW; i++) begin
      exp_full[i]  = (q[i].size() == DEPTH);
      exp_empty[i] = (q[i].size() == 0);
    end
    check("out_valid", 128'(out_valid), 128'(exp_v));
    check("warp_full", 128'(warp_full), 128'(exp_full));
    check("warp_empty", 128'(warp_empty), 128'(exp_empty));
    check("overflow", 128'(overflow), 128'(m_ovf));
    if (exp_v) begin
      check("out_warp_num", 128'(out_warp_num), 128'(sel));
      check("out_pc", 128'(out_pc), 128'(q[sel][0].pc));
      check("out_thread_mask", 128'(out_thread_mask), 128'(q[sel][0].mask));
      check("out_inst", out_inst, q[sel][0].inst);
    end
    if (out_valid && out_ready) begin
      iss_w.push_back(int'(out_warp_num));
      iss_pc.push_back(out_pc);
    end
    @(posedge clk);
    if (fv) q[fw].delete();
    if (exp_v && rdy) begin
      void'(q[sel].pop_front());
      m_rr = (sel + 1) % NW;
    end
    if (v && !(fv && fw == w)) begin
      if (q[w].size() < DEPTH) q[w].push_back(e);
      else m_ovf = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic push(input int w, input logic [31:0] pc);
    step(1'b1, w, pc, 1'b0, 0, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 0, 32'h0, 1'b0, 0, rdy);
  endtask

  // Reset asserted between clock edges; effects must be visible immediately.
  task automatic mid_reset();
    in_valid    = 1'b0;
    flush_valid = 1'b0;
    out_ready   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_warp_empty", 128'(warp_empty), 128'(8'hFF));
    check("rst_warp_full", 128'(warp_full), 128'(8'h00));
    check("rst_overflow", 128'(overflow), 128'(1'b0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_pc = '0; in_warp_num = '0; in_thread_mask = '0; in_inst = '0;
    flush_valid = 1'b0; flush_warp = '0; out_ready = 1'b0;
    model_reset();
    #1;
    check("reset_out_valid", 128'(out_valid), 128'(1'b0));
    check("reset_warp_empty", 128'(warp_empty), 128'(8'hFF));
    check("reset_warp_full", 128'(warp_full), 128'(8'h00));
    check("reset_overflow", 128'(overflow), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin order across warps 3,1,3.
    push(3, 32'h100); push(1, 32'h200); push(3, 32'h104);
    iss_w.delete(); iss_pc.delete();
    repeat (3) idle(1'b1);
    check("rr_n_issued", 128'(iss_w.size()), 128'(3));
    if (iss_w.size() == 3) begin
      check("rr0_warp", 128'(iss_w[0]), 128'(1)); check("rr0_pc", 128'(iss_pc[0]), 128'(32'h200));
      check("rr1_warp", 128'(iss_w[1]), 128'(3)); check("rr1_pc", 128'(iss_pc[1]), 128'(32'h100));
      check("rr2_warp", 128'(iss_w[2]), 128'(3)); check("rr2_pc", 128'(iss_pc[2]), 128'(32'h104));
    end
    // rr_ptr at 4: new entries on warps 2 and 5 -> warp 5 issues first.
    push(2, 32'h300); push(5, 32'h500);
    iss_w.delete(); iss_pc.delete();
    idle(1'b1);
    check("rr_ptr4_warp", 128'(iss_w.size() > 0 ? iss_w[0] : -1), 128'(5));
    idle(1'b1);

    // Fill warp 2, overflow on the fifth push, drain intact.
    mid_reset();
    for (int i = 0; i < DEPTH; i++) push(2, 32'h1000 + 32'(4 * i));
    check("w2_full", 128'(warp_full[2]), 128'(1'b1));
    push(2, 32'hDEAD);
    check("w2_overflow", 128'(overflow), 128'(1'b1));
    iss_pc.delete(); iss_w.delete();
    repeat (DEPTH + 1) idle(1'b1);
    check("w2_drain_n", 128'(iss_pc.size()), 128'(DEPTH));
    for (int i = 0; i < iss_pc.size(); i++) check("w2_drain_pc", 128'(iss_pc[i]), 128'(32'h1000 + 32'(4 * i)));

    // Full warp 5 accepts push while its head pops.
    mid_reset();
    for (int i = 0; i < DEPTH; i++) push(5, 32'h5000 + 32'(i));
    step(1'b1, 5, 32'h5FFF, 1'b0, 0, 1'b1);
    check("w5_still_full", 128'(warp_full[5]), 128'(1'b1));
    check("w5_no_overflow", 128'(overflow), 128'(1'b0));
    repeat (DEPTH + 1) idle(1'b1);

    // Flush warp 0 with same-cycle push; warp 6 issues meanwhile.
    mid_reset();
    push(0, 32'h10); push(0, 32'h14); push(6, 32'h60);
    iss_w.delete(); iss_pc.delete();
    step(1'b1, 0, 32'h18, 1'b1, 0, 1'b1);
    check("flush_sel6", 128'(iss_w.size() > 0 ? iss_w[0] : -1), 128'(6));
    check("flush_w0_empty", 128'(warp_empty[0]), 128'(1'b1));
    idle(1'b1);

    // One entry per warp drains in order 0..7.
    mid_reset();
    for (int w = 0; w < NW; w++) push(w, 32'h7000 + 32'(w));
    iss_w.delete(); iss_pc.delete();
    repeat (NW) idle(1'b1);
    check("sweep_n", 128'(iss_w.size()), 128'(NW));
    for (int i = 0; i < iss_w.size(); i++) check("sweep_order", 128'(iss_w[i]), 128'(i));
    idle(1'b1);
    check("sweep_all_empty", 128'(warp_empty), 128'(8'hFF));

    // Reset with 3 entries buffered, then warp 4 issues.
    push(1, 32'hA0); push(2, 32'hA4); push(3, 32'hA8);
    mid_reset();
    push(4, 32'h4444);
    iss_w.delete(); iss_pc.delete();
    idle(1'b1);
    check("post_rst_warp", 128'(iss_w.size() > 0 ? iss_w[0] : -1), 128'(4));
    check("post_rst_pc", 128'(iss_pc.size() > 0 ? iss_pc[0] : 32'h0), 128'(32'h4444));

    // Randomized traffic; pushes to full warps are rare so overflow stays useful.
    mid_reset();
    for (int n = 0; n < 3000; n++) begin
      int   w, fw;
      logic v, fv;
      w  = int'($urandom_range(0, NW - 1));
      fw = int'($urandom_range(0, NW - 1));
      v  = ($urandom_range(0, 99) < 60);
      if (v && q[w].size() == DEPTH && $urandom_range(0, 99) >= 5) v = 1'b0;
      fv = ($urandom_range(0, 99) < 4);
      if (n % 700 == 699) mid_reset();
      else step(v, w, $urandom, fv, fw, $urandom_range(0, 99) < 50);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
